// File: rtl/fabric_alu_pkg.sv
// Shared opcode encoding and ConfigBits field layout for the fabric ALU/accumulator.
package fabric_alu_pkg;

  typedef enum logic [2:0] {
    OP_ADD  = 3'b000,
    OP_SUB  = 3'b001,
    OP_ADD3 = 3'b010,
    OP_ACC  = 3'b011,
    OP_MAC  = 3'b100,
    OP_AND  = 3'b101,
    OP_OR   = 3'b110,
    OP_XOR  = 3'b111
  } alu_op_e;

  localparam int unsigned CFG_OP_LSB  = 0;
  localparam int unsigned CFG_OP_MSB  = 2;
  localparam int unsigned CFG_REG_OUT = 3;
  localparam int unsigned RESTART_BIT = 0;

endpackage

// File: rtl/fabric_alu_core.sv
// Combinational opcode decode, arithmetic/logic datapath and carry generation.
module fabric_alu_core
  import fabric_alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic [WIDTH-1:0] acc,
  input  alu_op_e          opcode,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic [WIDTH-1:0] next_acc
);

  logic [WIDTH:0]   sum_ab;
  logic [WIDTH:0]   diff_ab;
  logic [WIDTH:0]   sum_abc;
  logic [WIDTH-1:0] prod;
  logic [WIDTH-1:0] acc_operand;
  logic [WIDTH:0]   acc_sum;
  logic             restart;

  assign sum_ab      = {1'b0, a} + {1'b0, b};
  assign diff_ab     = {1'b0, a} - {1'b0, b};
  assign sum_abc     = {1'b0, sum_ab[WIDTH-1:0]} + {1'b0, c};
  assign prod        = a * b;
  assign acc_operand = (opcode == OP_MAC) ? prod : a;
  assign acc_sum     = {1'b0, acc} + {1'b0, acc_operand};
  assign restart     = c[RESTART_BIT];

  always_comb begin
    result   = '0;
    carry    = 1'b0;
    next_acc = acc;
    case (opcode)
      OP_ADD: begin
        result = sum_ab[WIDTH-1:0];
        carry  = sum_ab[WIDTH];
      end
      OP_SUB: begin
        result = diff_ab[WIDTH-1:0];
        carry  = ~diff_ab[WIDTH];
      end
      OP_ADD3: begin
        result = sum_abc[WIDTH-1:0];
        carry  = sum_ab[WIDTH] | sum_abc[WIDTH];
      end
      OP_ACC, OP_MAC: begin
        // Restart loads the operand directly, so no carry can be produced.
        if (restart) begin
          next_acc = acc_operand;
          carry    = 1'b0;
        end else begin
          next_acc = acc_sum[WIDTH-1:0];
          carry    = acc_sum[WIDTH];
        end
        result = next_acc;
      end
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_XOR:  result = a ^ b;
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/fabric_alu_acc.sv
// Fabric ALU/accumulator tile primitive: owns acc, the optional output register and valid strobe.
module fabric_alu_acc
  import fabric_alu_pkg::*;
#(
  parameter int unsigned WIDTH        = 32,
  parameter int unsigned NoConfigBits = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic [WIDTH-1:0]        data_in1,
  input  logic [WIDTH-1:0]        data_in2,
  input  logic [WIDTH-1:0]        data_in3,
  input  logic [NoConfigBits-1:0] ConfigBits,
  output logic [WIDTH-1:0]        data_out,
  output logic                    carry_out,
  output logic                    out_valid
);

  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             carry_q, carry_d;
  logic             valid_q, valid_d;

  logic [WIDTH-1:0] core_result;
  logic             core_carry;
  logic [WIDTH-1:0] core_next_acc;
  logic             reg_out;
  alu_op_e          opcode;

  assign opcode  = alu_op_e'(ConfigBits[CFG_OP_MSB:CFG_OP_LSB]);
  assign reg_out = ConfigBits[CFG_REG_OUT];

  fabric_alu_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .a        (data_in1),
    .b        (data_in2),
    .c        (data_in3),
    .acc      (acc_q),
    .opcode   (opcode),
    .result   (core_result),
    .carry    (core_carry),
    .next_acc (core_next_acc)
  );

  always_comb begin
    acc_d   = acc_q;
    out_d   = out_q;
    carry_d = carry_q;
    valid_d = en;
    if (en) begin
      acc_d   = core_next_acc;
      out_d   = core_result;
      carry_d = core_carry;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      acc_q   <= '0;
      out_q   <= '0;
      carry_q <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      acc_q   <= acc_d;
      out_q   <= out_d;
      carry_q <= carry_d;
      valid_q <= valid_d;
    end
  end

  assign data_out  = reg_out ? out_q   : core_result;
  assign carry_out = reg_out ? carry_q : core_carry;
  assign out_valid = reg_out ? valid_q : en;

endmodule

// File: doc/fabric_alu_acc.md
Name: fabric_alu_acc

Overview:
- Parametrised successor of the fabric ALU primitive targeted by the `std_add` techmap.
- Width is generic and the opcode is configurable: add, sub, three-input add, accumulate, multiply-accumulate and bitwise ops.
- Has a selectable registered output, a carry flag and an output valid strobe.
- Sits in a fabric tile as a techmap target for `std_add`, `std_sub` and `std_mac` cells. Its ConfigBits are driven by the tile config chain.

Parameters:
- WIDTH, 32, datapath width in bits (legal range 4..64).
- NoConfigBits, 4, width of the ConfigBits field. Fixed at 4 for this layout.

Ports:
- clk  input  1  fabric clock; all state updates on the rising edge.
- rst  input  1  synchronous active-low reset.
- en  input  1  input-valid / clock-enable. State updates only when en=1.
- data_in1  input  WIDTH  operand A.
- data_in2  input  WIDTH  operand B.
- data_in3  input  WIDTH  operand C for ADD3. In ACC/MAC, bit 0 = restart.
- ConfigBits  input  NoConfigBits  [2:0] opcode, [3] REG_OUT.
- data_out  output  WIDTH  result.
- carry_out  output  1  carry/no-borrow of the last arithmetic op.
- out_valid  output  1  data_out holds a result produced by an en=1 cycle.

Behaviour:
- Reset: rst=0 sampled at a posedge clears acc, the output register, carry_out and out_valid to 0. Reset overrides en and any opcode. Reset mid-accumulation discards acc.
- Opcodes, with results taken mod 2^WIDTH:
  - 000 ADD: A+B. carry = bit WIDTH of the sum.
  - 001 SUB: A-B. carry = 1 when A>=B (unsigned).
  - 010 ADD3: A+B+C. carry = OR of both adder carries.
  - 011 ACC: acc <= acc+A, or acc <= A if restart. Result = new acc.
  - 100 MAC: acc <= acc+low_WIDTH(A*B), or acc <= low_WIDTH(A*B) if restart. Result = new acc.
  - 101 AND, 110 OR, 111 XOR: carry forced to 0.
- acc is WIDTH bits and wraps silently. For ACC/MAC, carry = carry out of the acc add; on restart, carry = 0.
- The multiplier keeps only the low WIDTH bits. There is no signed mode.
- REG_OUT=1:
  - data_out and carry_out are registered. Latency 1: the result of an en=1 cycle appears after the next posedge.
  - With en=0 the outputs hold.
  - out_valid <= en each cycle.
- REG_OUT=0:
  - data_out and carry_out are combinational from the current inputs.
  - For ACC/MAC they show the value acc will take if en=1. Otherwise they show acc+operand without committing it.
  - out_valid = en (combinational).
- en=0: acc, the output register and carry hold. out_valid drops after the next posedge (REG_OUT=1) or immediately (REG_OUT=0).
- Opcode change between cycles: acc keeps its value and is not implicitly cleared. Switching from ACC to MAC continues from the current acc.
- Changing REG_OUT at runtime is illegal. Only a reset defines behaviour after such a change.
- Unused data_in3 bits are ignored. data_in3 is don't-care for ops other than ADD3/ACC/MAC.
- No X may propagate from unconnected data_in3: it is treated as 0 by the techmap.

Decomposition:
- Package fabric_alu_pkg holds:
  - opcode localparams OP_ADD..OP_XOR;
  - config field indices CFG_OP_LSB=0, CFG_OP_MSB=2, CFG_REG_OUT=3;
  - RESTART_BIT=0.
- Sub-module fabric_alu_core holds the purely combinational opcode decode, add/sub/mul/logic and carry generation. It has inputs A, B, C, acc and opcode, and outputs result, carry and next_acc.
- The top level owns the acc register, the output register, out_valid and the REG_OUT mux.

Test Plan:
1. WIDTH=32, REG_OUT=1, ADD. A=0xFFFFFFFF, B=1, en=1 for one cycle -> next cycle data_out=0, carry_out=1, out_valid=1. The cycle after: out_valid=0 and data_out holds 0.
2. SUB, REG_OUT=0. A=5, B=7 -> data_out=0xFFFFFFFE, carry_out=0 combinationally. A=7, B=5 -> data_out=2, carry_out=1.
3. MAC, REG_OUT=1. Restart with A=3, B=4, then en cycles (2,5) and (10,10) -> data_out sequence 12, 22, 122. An en=0 gap between cycles leaves acc unchanged.
4. ACC. acc=0xFFFFFFF0 via restart, then A=0x20 -> data_out=0x10, carry_out=1. A following restart with A=7 -> data_out=7, carry_out=0.
5. ACC with acc=100. Assert rst=0 together with en=1 and A=5 -> after the edge acc=0, data_out=0, out_valid=0. Then A=5 without restart -> data_out=5.
6. XOR/AND/OR with A=0xF0F0F0F0, B=0xFF00FF00 -> data_out 0x0FF00FF0 / 0xF000F000 / 0xFFF0FFF0, carry_out=0. Repeat at WIDTH=8 for the mod-2^WIDTH wrap.
